// File: rtl/counter_check_pkg.sv
// rtl/counter_check_pkg.sv - state encoding and default parameters for the counter checker
package counter_check_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACQ  = 2'd1,
        ST_LOCK = 2'd2
    } state_t;

    localparam int DEF_WIDTH    = 32;
    localparam int DEF_STAT_W   = 16;
    localparam int DEF_SYNC_LEN = 4;

endpackage

// File: rtl/counter_checker_32bits_sat_counter.sv
// rtl/counter_checker_32bits_sat_counter.sv - saturating statistics counter with synchronous clear
module sat_counter #(
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              clr,
    input  logic              inc,
    output logic [STAT_W-1:0] cnt
);

    logic [STAT_W-1:0] r_cnt;

    // clear outranks a same-cycle increment
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != {STAT_W{1'b1}})) begin
            r_cnt <= r_cnt + {{(STAT_W-1){1'b0}}, 1'b1};
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/counter_checker_32bits.sv
// rtl/counter_checker_32bits.sv - passive sequence checker for a free-running counter
// Optional first-error capture ports are built when COUNTER_CHECKER_FIRST_ERR_EN is defined.
module counter_checker_32bits
    import counter_check_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int SYNC_LEN = DEF_SYNC_LEN,
    parameter int STAT_W   = DEF_STAT_W
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              en,
    input  logic              cnt_rst,
    input  logic [WIDTH-1:0]  cnt_in,
    input  logic              clr_stat,
    output logic              locked,
    output logic              err_pulse,
    output logic              err_sticky,
    output logic [STAT_W-1:0] err_count,
    output logic              wrap_pulse,
    output logic [STAT_W-1:0] wrap_count
`ifdef COUNTER_CHECKER_FIRST_ERR_EN
    ,
    output logic [WIDTH-1:0]  first_exp,
    output logic [WIDTH-1:0]  first_act,
    output logic              first_valid
`endif
);

    localparam logic [WIDTH-1:0] ONE    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [3:0]       SYNC_N = 4'(SYNC_LEN);

    state_t           r_state;
    logic [WIDTH-1:0] r_prev_cnt;
    logic             r_prev_en;
    logic             r_prev_rst;
    logic [3:0]       r_match_cnt;
    logic             r_locked;
    logic             r_err_pulse;
    logic             r_err_sticky;
    logic             r_wrap_pulse;

    logic [WIDTH-1:0] w_exp;
    logic             w_match;
    logic             w_err;
    logic             w_wrap;
    logic [3:0]       w_match_inc;

    assign w_exp       = r_prev_rst ? '0 : (r_prev_en ? r_prev_cnt + ONE : r_prev_cnt);
    assign w_match     = (cnt_in == w_exp);
    assign w_err       = (r_state == ST_LOCK) && !w_match;
    // a counter reset also lands on 0, so prev_rst must be low for a wrap
    assign w_wrap      = (r_state == ST_LOCK) && w_match && !r_prev_rst && r_prev_en
                         && (&r_prev_cnt) && (cnt_in == '0);
    assign w_match_inc = r_match_cnt + 4'd1;

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_state      <= ST_IDLE;
            r_prev_cnt   <= '0;
            r_prev_en    <= 1'b0;
            r_prev_rst   <= 1'b0;
            r_match_cnt  <= 4'd0;
            r_locked     <= 1'b0;
            r_err_pulse  <= 1'b0;
            r_err_sticky <= 1'b0;
            r_wrap_pulse <= 1'b0;
        end else begin
            r_prev_cnt   <= cnt_in;
            r_prev_en    <= en;
            r_prev_rst   <= cnt_rst;
            r_err_pulse  <= w_err;
            r_wrap_pulse <= w_wrap;
            if (clr_stat) begin
                r_err_sticky <= 1'b0;
            end else if (w_err) begin
                r_err_sticky <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    r_state     <= ST_ACQ;
                    r_match_cnt <= 4'd0;
                end
                ST_ACQ: begin
                    if (!w_match) begin
                        r_match_cnt <= 4'd0;
                    end else if (w_match_inc == SYNC_N) begin
                        r_state     <= ST_LOCK;
                        r_match_cnt <= 4'd0;
                        r_locked    <= 1'b1;
                    end else begin
                        r_match_cnt <= w_match_inc;
                    end
                end
                ST_LOCK: begin
                    if (!w_match) begin
                        r_state     <= ST_ACQ;
                        r_match_cnt <= 4'd0;
                        r_locked    <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_match_cnt <= 4'd0;
                    r_locked    <= 1'b0;
                end
            endcase
        end
    end

    sat_counter #(.STAT_W(STAT_W)) u_err_cnt (
        .clk     (clk),
        .n_reset (n_reset),
        .clr     (clr_stat),
        .inc     (w_err),
        .cnt     (err_count)
    );

    sat_counter #(.STAT_W(STAT_W)) u_wrap_cnt (
        .clk     (clk),
        .n_reset (n_reset),
        .clr     (clr_stat),
        .inc     (w_wrap),
        .cnt     (wrap_count)
    );

    assign locked     = r_locked;
    assign err_pulse  = r_err_pulse;
    assign err_sticky = r_err_sticky;
    assign wrap_pulse = r_wrap_pulse;

`ifdef COUNTER_CHECKER_FIRST_ERR_EN
    logic [WIDTH-1:0] r_first_exp;
    logic [WIDTH-1:0] r_first_act;
    logic             r_first_valid;

    // only the first error since reset/clear is kept
    always_ff @(posedge clk) begin
        if (!n_reset || clr_stat) begin
            r_first_exp   <= '0;
            r_first_act   <= '0;
            r_first_valid <= 1'b0;
        end else if (w_err && !r_first_valid) begin
            r_first_exp   <= w_exp;
            r_first_act   <= cnt_in;
            r_first_valid <= 1'b1;
        end
    end

    assign first_exp   = r_first_exp;
    assign first_act   = r_first_act;
    assign first_valid = r_first_valid;
`endif

endmodule

// File: tb/tb_counter_checker_32bits.sv
// tb/tb_counter_checker_32bits.sv - directed self-checking bench for counter_checker_32bits
module tb_counter_checker_32bits;

    logic        clk;
    logic        n_reset;
    logic        en;
    logic        cnt_rst;
    logic [31:0] cnt_in;
    logic        clr_stat;
    logic        locked;
    logic        err_pulse;
    logic        err_sticky;
    logic [1:0]  err_count;
    logic        wrap_pulse;
    logic [1:0]  wrap_count;
`ifdef COUNTER_CHECKER_FIRST_ERR_EN
    logic [31:0] first_exp;
    logic [31:0] first_act;
    logic        first_valid;
`endif

    int n_checks = 0;
    int n_errors = 0;

    counter_checker_32bits #(.WIDTH(32), .SYNC_LEN(4), .STAT_W(2)) dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .en         (en),
        .cnt_rst    (cnt_rst),
        .cnt_in     (cnt_in),
        .clr_stat   (clr_stat),
        .locked     (locked),
        .err_pulse  (err_pulse),
        .err_sticky (err_sticky),
        .err_count  (err_count),
        .wrap_pulse (wrap_pulse),
        .wrap_count (wrap_count)
`ifdef COUNTER_CHECKER_FIRST_ERR_EN
        ,
        .first_exp  (first_exp),
        .first_act  (first_act),
        .first_valid(first_valid)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step(input logic e, input logic r, input logic [31:0] c);
        @(negedge clk);
        en      = e;
        cnt_rst = r;
        cnt_in  = c;
        @(posedge clk);
        #1;
    endtask

    task automatic relock(inout logic [31:0] v);
        for (int k = 0; k < 4; k++) begin
            v = v + 32'd1;
            step(1'b1, 1'b0, v);
        end
    endtask

    logic [31:0] v;

    initial begin
        n_reset  = 1'b0;
        en       = 1'b0;
        cnt_rst  = 1'b0;
        cnt_in   = '0;
        clr_stat = 1'b0;
        step(1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0);
        check_val("rst_locked", locked, 0);
        check_val("rst_err_pulse", err_pulse, 0);
        check_val("rst_sticky", err_sticky, 0);
        check_val("rst_err_count", err_count, 0);
        check_val("rst_wrap_count", wrap_count, 0);
`ifdef COUNTER_CHECKER_FIRST_ERR_EN
        check_val("rst_first_valid", first_valid, 0);
`endif

        // lock-in: locked after the sample 4
        n_reset = 1'b1;
        for (int i = 0; i <= 5; i++) begin
            step(1'b1, 1'b0, 32'(i));
            check_val($sformatf("lockin_%0d", i), locked, (i >= 4) ? 1 : 0);
        end
        check_val("lockin_err_count", err_count, 0);

        // hold at 0x10 with en=0, then jump to 0x13
        for (int i = 6; i <= 15; i++) step(1'b1, 1'b0, 32'(i));
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 32'h10);
            check_val("hold_locked", locked, 1);
            check_val("hold_err_pulse", err_pulse, 0);
        end
        step(1'b1, 1'b0, 32'h13);
        check_val("jump_err_pulse", err_pulse, 1);
        check_val("jump_err_count", err_count, 1);
        check_val("jump_sticky", err_sticky, 1);
        check_val("jump_locked", locked, 0);
        step(1'b1, 1'b0, 32'h14);
        check_val("jump_pulse_1cyc", err_pulse, 0);
        step(1'b1, 1'b0, 32'h15);
        step(1'b1, 1'b0, 32'h16);
        check_val("relock_early", locked, 0);
        step(1'b1, 1'b0, 32'h17);
        check_val("relock", locked, 1);

        // wrap: resync near the top, then FE, FF, 0
        step(1'b1, 1'b0, 32'hFFFF_FFF9);
        check_val("wrap_pre_err_count", err_count, 2);
        v = 32'hFFFF_FFF9;
        relock(v);
        check_val("wrap_pre_locked", locked, 1);
        step(1'b1, 1'b0, 32'hFFFF_FFFE);
        check_val("wrap_fe", wrap_pulse, 0);
        step(1'b1, 1'b0, 32'hFFFF_FFFF);
        check_val("wrap_ff", wrap_pulse, 0);
        step(1'b1, 1'b0, 32'h0);
        check_val("wrap_pulse", wrap_pulse, 1);
        check_val("wrap_count", wrap_count, 1);
        check_val("wrap_no_err", err_pulse, 0);
        check_val("wrap_locked", locked, 1);
        step(1'b1, 1'b0, 32'h1);
        check_val("wrap_pulse_1cyc", wrap_pulse, 0);

        // counter reset at 0x55 is a match, not a wrap
        for (int i = 2; i <= 32'h54; i++) step(1'b1, 1'b0, 32'(i));
        step(1'b1, 1'b1, 32'h55);
        step(1'b1, 1'b0, 32'h0);
        check_val("crst_locked", locked, 1);
        check_val("crst_no_wrap", wrap_pulse, 0);
        check_val("crst_no_err", err_pulse, 0);
        check_val("crst_wrap_count", wrap_count, 1);

        // clear, then saturation at 3 with a 2-bit counter
        clr_stat = 1'b1;
        step(1'b1, 1'b0, 32'h1);
        clr_stat = 1'b0;
        check_val("clr_err_count", err_count, 0);
        check_val("clr_sticky", err_sticky, 0);
        check_val("clr_wrap_count", wrap_count, 0);
        v = 32'h1;
        for (int k = 1; k <= 5; k++) begin
            v = v + 32'h100;
            step(1'b1, 1'b0, v);
            check_val($sformatf("sat_pulse_%0d", k), err_pulse, 1);
            check_val($sformatf("sat_count_%0d", k), err_count, (k > 3) ? 3 : k);
            relock(v);
            check_val($sformatf("sat_relock_%0d", k), locked, 1);
        end
        v = v + 32'h100;
        clr_stat = 1'b1;
        step(1'b1, 1'b0, v);
        clr_stat = 1'b0;
        check_val("clrwin_count", err_count, 0);
        check_val("clrwin_sticky", err_sticky, 0);
        check_val("clrwin_pulse", err_pulse, 1);

        // mid-run reset while locked
        relock(v);
        check_val("mid_pre_locked", locked, 1);
        n_reset = 1'b0;
        step(1'b1, 1'b0, v + 32'd1);
        n_reset = 1'b1;
        check_val("mid_locked", locked, 0);
        check_val("mid_err_count", err_count, 0);
        check_val("mid_wrap_count", wrap_count, 0);
        check_val("mid_sticky", err_sticky, 0);
        for (int i = 0; i <= 32'h20; i++) begin
            step(1'b1, 1'b0, 32'(i));
            if (i == 3) check_val("mid_acq_4", locked, 0);
            if (i == 4) check_val("mid_acq_5", locked, 1);
        end
`ifdef COUNTER_CHECKER_FIRST_ERR_EN
        check_val("first_valid_pre", first_valid, 0);
`endif
        step(1'b1, 1'b0, 32'h40);
        check_val("mid_err_pulse", err_pulse, 1);
        check_val("mid_err_count1", err_count, 1);
`ifdef COUNTER_CHECKER_FIRST_ERR_EN
        check_val("first_exp", first_exp, 32'h21);
        check_val("first_act", first_act, 32'h40);
        check_val("first_valid", first_valid, 1);
`endif
        v = 32'h40;
        relock(v);
        step(1'b1, 1'b0, 32'h90);
        check_val("mid_err_count2", err_count, 2);
`ifdef COUNTER_CHECKER_FIRST_ERR_EN
        check_val("first_exp_keep", first_exp, 32'h21);
        check_val("first_act_keep", first_act, 32'h40);
        check_val("first_valid_keep", first_valid, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
